// File: rtl/coproc_wb_arbiter_if.sv
// ---------------------------------------------------------------------------
// coproc_wb_arbiter_if
//
// Bundles every signal around the register-file write-back arbiter except
// clock and reset.
//
//   Core write-back side : core_we, core_addr, core_data
//   Coprocessor side     : cp_req, cp_ready, cp_base, cp_nwords, cp_result,
//                          cp_done, cp_err, busy, stall_cnt
//   Register file side   : rf_we, rf_addr, rf_data
//
// Modports:
//   slave  - the arbiter itself (consumes requests, produces rf_* writes)
//   master - the surrounding pipeline / coprocessors / testbench
// ---------------------------------------------------------------------------
interface coproc_wb_arbiter_if #(
    parameter int XLEN      = 32,
    parameter int MAX_WORDS = 8,
    parameter int CNT_W     = 8
);
    logic                      core_we;
    logic [4:0]                core_addr;
    logic [XLEN-1:0]           core_data;

    logic                      cp_req;
    logic                      cp_ready;
    logic [4:0]                cp_base;
    logic [3:0]                cp_nwords;
    logic [XLEN*MAX_WORDS-1:0] cp_result;

    logic                      rf_we;
    logic [4:0]                rf_addr;
    logic [XLEN-1:0]           rf_data;

    logic                      cp_done;
    logic                      cp_err;
    logic                      busy;
    logic [CNT_W-1:0]          stall_cnt;

    modport slave (
        input  core_we, core_addr, core_data,
        input  cp_req, cp_base, cp_nwords, cp_result,
        output cp_ready, rf_we, rf_addr, rf_data,
        output cp_done, cp_err, busy, stall_cnt
    );

    modport master (
        output core_we, core_addr, core_data,
        output cp_req, cp_base, cp_nwords, cp_result,
        input  cp_ready, rf_we, rf_addr, rf_data,
        input  cp_done, cp_err, busy, stall_cnt
    );
endinterface

// File: rtl/coproc_wb_arbiter.sv
// ---------------------------------------------------------------------------
// coproc_wb_arbiter
//
// Shares the register file's single write port between the core write-back
// stage and wide-result coprocessors. A coprocessor result (up to MAX_WORDS
// words of XLEN bits) is captured in one handshake and then drained one word
// per free port cycle to registers base, base+1, ... (mod 32). The core
// always wins the port; every cycle the coprocessor loses is counted in a
// saturating stall counter.
//
// Ports:
//   CLK  - system clock
//   RST  - asynchronous reset, active-high
//   bus  - coproc_wb_arbiter_if.slave
//            core_we/core_addr/core_data    core write-back request
//            cp_req/cp_ready                result handshake
//            cp_base/cp_nwords/cp_result    captured result descriptor
//            rf_we/rf_addr/rf_data          registered register-file write
//            cp_done/cp_err                 completion pulses
//            busy                           transfer in progress
//            stall_cnt                      cycles denied in current/last transfer
// ---------------------------------------------------------------------------
module coproc_wb_arbiter #(
    parameter int XLEN      = 32,
    parameter int MAX_WORDS = 8,
    parameter int CNT_W     = 8
) (
    input  logic                CLK,
    input  logic                RST,
    coproc_wb_arbiter_if.slave  bus
);

    localparam int         IDX_W = (MAX_WORDS > 1) ? $clog2(MAX_WORDS) : 1;
    localparam logic [3:0] MAX_N = 4'(MAX_WORDS);

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        DONE
    } state_t;

    state_t                    state_q, state_n;
    logic [XLEN*MAX_WORDS-1:0] res_q, res_n;
    logic [4:0]                base_q, base_n;
    logic [3:0]                nwords_q, nwords_n;
    logic [IDX_W-1:0]          idx_q, idx_n;
    logic [CNT_W-1:0]          stall_q, stall_n;

    logic                      rf_we_q, rf_we_n;
    logic [4:0]                rf_addr_q, rf_addr_n;
    logic [XLEN-1:0]           rf_data_q, rf_data_n;
    logic                      done_q, done_n;
    logic                      err_q, err_n;

    logic [4:0]                word_addr;
    logic                      last_word;
    logic                      n_legal;

    // Destination of the pending word wraps naturally in 5 bits, so a
    // transfer starting near x31 continues at x0, x1, ...
    always_comb begin
        word_addr = base_q + 5'(idx_q);
        last_word = (4'(idx_q) == (nwords_q - 4'd1));
        n_legal   = (bus.cp_nwords != 4'd0) && (bus.cp_nwords <= MAX_N);
    end

    // Next-state and output decode. rf_addr/rf_data keep their last value
    // whenever nothing is granted, including a suppressed x0 word.
    always_comb begin
        state_n   = state_q;
        res_n     = res_q;
        base_n    = base_q;
        nwords_n  = nwords_q;
        idx_n     = idx_q;
        stall_n   = stall_q;
        rf_we_n   = 1'b0;
        rf_addr_n = rf_addr_q;
        rf_data_n = rf_data_q;
        done_n    = 1'b0;
        err_n     = 1'b0;

        // The core path is independent of the state: it always owns the port.
        if (bus.core_we) begin
            rf_we_n   = 1'b1;
            rf_addr_n = bus.core_addr;
            rf_data_n = bus.core_data;
        end

        case (state_q)
            IDLE: begin
                if (bus.cp_req) begin
                    res_n    = bus.cp_result;
                    base_n   = bus.cp_base;
                    nwords_n = bus.cp_nwords;
                    idx_n    = '0;
                    stall_n  = '0;
                    state_n  = n_legal ? WRITE : DONE;
                end
            end

            WRITE: begin
                if (bus.core_we) begin
                    if (stall_q != {CNT_W{1'b1}}) begin
                        stall_n = stall_q + 1'b1;
                    end
                end else begin
                    // x0 is hard-wired zero: the slot is consumed but not written.
                    if (word_addr != 5'd0) begin
                        rf_we_n   = 1'b1;
                        rf_addr_n = word_addr;
                        rf_data_n = res_q[XLEN*idx_q +: XLEN];
                    end
                    if (last_word) begin
                        done_n  = 1'b1;
                        state_n = IDLE;
                    end else begin
                        idx_n = idx_q + 1'b1;
                    end
                end
            end

            DONE: begin
                done_n  = 1'b1;
                err_n   = 1'b1;
                state_n = IDLE;
            end

            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // Reset abandons any in-flight transfer without a completion pulse.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= IDLE;
            res_q     <= '0;
            base_q    <= '0;
            nwords_q  <= '0;
            idx_q     <= '0;
            stall_q   <= '0;
            rf_we_q   <= 1'b0;
            rf_addr_q <= '0;
            rf_data_q <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_n;
            res_q     <= res_n;
            base_q    <= base_n;
            nwords_q  <= nwords_n;
            idx_q     <= idx_n;
            stall_q   <= stall_n;
            rf_we_q   <= rf_we_n;
            rf_addr_q <= rf_addr_n;
            rf_data_q <= rf_data_n;
            done_q    <= done_n;
            err_q     <= err_n;
        end
    end

    assign bus.cp_ready  = (state_q == IDLE);
    assign bus.busy      = (state_q != IDLE);
    assign bus.rf_we     = rf_we_q;
    assign bus.rf_addr   = rf_addr_q;
    assign bus.rf_data   = rf_data_q;
    assign bus.cp_done   = done_q;
    assign bus.cp_err    = err_q;
    assign bus.stall_cnt = stall_q;

endmodule

// File: tb/tb_coproc_wb_arbiter.sv
// ---------------------------------------------------------------------------
// tb_coproc_wb_arbiter
//
// Drives the arbiter through its interface on the falling clock edge and
// predicts, from a queue-of-pending-words model, what must appear after the
// next rising edge. Predicted register writes, completion pulses and status
// are queued with the edge number they belong to; an independent monitor
// samples just after each rising edge and pops/compares.
// ---------------------------------------------------------------------------
module tb_coproc_wb_arbiter;

    localparam int XLEN      = 32;
    localparam int MAX_WORDS = 8;
    localparam int CNT_W     = 8;
    localparam int STALL_MAX = (1 << CNT_W) - 1;

    typedef struct {
        int          cyc;
        logic [4:0]  addr;
        logic [31:0] data;
    } wr_t;

    typedef struct {
        int cyc;
        bit err;
        int stall;
    } done_t;

    typedef struct {
        int cyc;
        bit busy;
        int stall;
    } st_t;

    logic CLK = 1'b0;
    logic RST = 1'b1;

    always #5 CLK = ~CLK;

    coproc_wb_arbiter_if #(.XLEN(XLEN), .MAX_WORDS(MAX_WORDS), .CNT_W(CNT_W)) bus ();

    coproc_wb_arbiter #(.XLEN(XLEN), .MAX_WORDS(MAX_WORDS), .CNT_W(CNT_W)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    int errors = 0;
    int checks = 0;
    int edge_cnt = 0;

    always @(posedge CLK) edge_cnt <= edge_cnt + 1;

    // Reference model: the outstanding transfer is just a list of words.
    bit    m_active = 1'b0;
    bit    m_err    = 1'b0;
    int    m_stall  = 0;
    wr_t   pend[$];
    wr_t   wq[$];
    done_t dq[$];
    st_t   sq[$];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s @edge %0d: got 0x%0h expected 0x%0h", name, edge_cnt, act, exp);
        end
    endtask

    // One clock of stimulus plus the model's prediction for the coming edge.
    task automatic applyStimulus(input bit we, input logic [4:0] a, input logic [31:0] d,
                                 input bit req, input logic [4:0] b, input logic [3:0] n,
                                 input logic [XLEN*MAX_WORDS-1:0] r);
        int  k;
        wr_t w;
        logic [4:0] pa;
        @(negedge CLK);
        bus.core_we   = we;
        bus.core_addr = a;
        bus.core_data = d;
        bus.cp_req    = req;
        bus.cp_base   = b;
        bus.cp_nwords = n;
        bus.cp_result = r;
        k = edge_cnt + 1;

        if (we) wq.push_back('{k, a, d});

        if (!m_active) begin
            if (req) begin
                m_active = 1'b1;
                m_stall  = 0;
                if (n >= 4'd1 && int'(n) <= MAX_WORDS) begin
                    for (int i = 0; i < int'(n); i++) begin
                        pa = b + 5'(i);
                        pend.push_back('{0, pa, r[32*i +: 32]});
                    end
                end else begin
                    m_err = 1'b1;
                end
            end
        end else if (m_err) begin
            dq.push_back('{k, 1'b1, m_stall});
            m_err    = 1'b0;
            m_active = 1'b0;
        end else if (we) begin
            if (m_stall < STALL_MAX) m_stall++;
        end else begin
            w = pend.pop_front();
            if (w.addr != 5'd0) wq.push_back('{k, w.addr, w.data});
            if (pend.size() == 0) begin
                dq.push_back('{k, 1'b0, m_stall});
                m_active = 1'b0;
            end
        end

        sq.push_back('{k, m_active, m_stall});
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 4'd0, '0);
    endtask

    task automatic startTransfer(input logic [4:0] b, input logic [3:0] n,
                                 input logic [XLEN*MAX_WORDS-1:0] r);
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, b, n, r);
    endtask

    task automatic resetPulse();
        @(negedge CLK);
        RST = 1'b1;
        bus.core_we = 1'b0;
        bus.cp_req  = 1'b0;
        pend.delete();
        wq.delete();
        dq.delete();
        sq.delete();
        m_active = 1'b0;
        m_err    = 1'b0;
        m_stall  = 0;
        #1;
        checkOutput("reset_rf_we",    32'(bus.rf_we),     32'd0);
        checkOutput("reset_rf_addr",  32'(bus.rf_addr),   32'd0);
        checkOutput("reset_rf_data",  bus.rf_data,        32'd0);
        checkOutput("reset_cp_done",  32'(bus.cp_done),   32'd0);
        checkOutput("reset_cp_err",   32'(bus.cp_err),    32'd0);
        checkOutput("reset_busy",     32'(bus.busy),      32'd0);
        checkOutput("reset_cp_ready", 32'(bus.cp_ready),  32'd1);
        checkOutput("reset_stall",    32'(bus.stall_cnt), 32'd0);
        @(negedge CLK);
        @(negedge CLK);
        RST = 1'b0;
    endtask

    // Monitor: compares whatever the DUT presents after each rising edge.
    always @(posedge CLK) begin
        wr_t   w;
        done_t dn;
        st_t   s;
        int    k;
        #1;
        if (!RST) begin
            k = edge_cnt;
            if (wq.size() > 0 && wq[0].cyc == k) begin
                w = wq.pop_front();
                checkOutput("rf_we", 32'(bus.rf_we), 32'd1);
                checkOutput("rf_addr", 32'(bus.rf_addr), 32'(w.addr));
                checkOutput("rf_data", bus.rf_data, w.data);
            end else begin
                checkOutput("rf_we_unexpected", 32'(bus.rf_we), 32'd0);
            end

            if (dq.size() > 0 && dq[0].cyc == k) begin
                dn = dq.pop_front();
                checkOutput("cp_done", 32'(bus.cp_done), 32'd1);
                checkOutput("cp_err", 32'(bus.cp_err), 32'(dn.err));
                checkOutput("done_stall", 32'(bus.stall_cnt), 32'(dn.stall));
            end else begin
                checkOutput("cp_done_unexpected", 32'(bus.cp_done), 32'd0);
                checkOutput("cp_err_unexpected", 32'(bus.cp_err), 32'd0);
            end

            if (sq.size() > 0 && sq[0].cyc == k) begin
                s = sq.pop_front();
                checkOutput("busy", 32'(bus.busy), 32'(s.busy));
                checkOutput("cp_ready", 32'(bus.cp_ready), 32'(!s.busy));
                checkOutput("stall_cnt", 32'(bus.stall_cnt), 32'(s.stall));
            end
        end
    end

    initial begin
        logic [XLEN*MAX_WORDS-1:0] res;
        logic [3:0] n;
        int drain;

        bus.core_we   = 1'b0;
        bus.core_addr = '0;
        bus.core_data = '0;
        bus.cp_req    = 1'b0;
        bus.cp_base   = '0;
        bus.cp_nwords = '0;
        bus.cp_result = '0;

        resetPulse();

        // Plain core write.
        applyStimulus(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 4'd0, '0);
        idleCycles(2);

        // Four-word transfer, no core traffic.
        res = '0;
        res[31:0] = 32'h11; res[63:32] = 32'h22; res[95:64] = 32'h33; res[127:96] = 32'h44;
        startTransfer(5'd8, 4'd4, res);
        idleCycles(5);

        // Same transfer with two core writes in WRITE cycles 2 and 3.
        startTransfer(5'd8, 4'd4, res);
        idleCycles(1);
        applyStimulus(1'b1, 5'd3, 32'hAA, 1'b0, 5'd0, 4'd0, '0);
        applyStimulus(1'b1, 5'd3, 32'hAA, 1'b0, 5'd0, 4'd0, '0);
        idleCycles(5);

        // Address wrap through x0.
        startTransfer(5'd30, 4'd4, res);
        idleCycles(5);

        // Illegal word counts.
        startTransfer(5'd4, 4'd0, res);
        idleCycles(3);
        startTransfer(5'd4, 4'd9, res);
        idleCycles(3);

        // Reset after two of four words, then a fresh transfer.
        startTransfer(5'd8, 4'd4, res);
        idleCycles(2);
        resetPulse();
        startTransfer(5'd16, 4'd2, res);
        idleCycles(4);

        // Randomized traffic.
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < MAX_WORDS; i++) res[32*i +: 32] = $urandom;
            if ($urandom_range(0, 15) < 12) n = 4'($urandom_range(1, MAX_WORDS));
            else if ($urandom_range(0, 1) == 0) n = 4'd0;
            else n = 4'($urandom_range(MAX_WORDS + 1, 15));
            applyStimulus($urandom_range(0, 2) == 0, 5'($urandom_range(0, 31)), $urandom,
                          $urandom_range(0, 3) == 0, 5'($urandom_range(0, 31)), n, res);
        end

        drain = 0;
        while (m_active && drain < 50) begin
            idleCycles(1);
            drain++;
        end
        checkOutput("drain_timeout", 32'(m_active), 32'd0);
        idleCycles(2);
        @(negedge CLK);
        checkOutput("wq_empty", 32'(wq.size()), 32'd0);
        checkOutput("dq_empty", 32'(dq.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
